// File: rtl/drac_pkg.sv
// drac_pkg: core-wide types shared with the prefetcher
//   addr_t : one CPU address (40 bits)
package drac_pkg;
    typedef logic [39:0] addr_t;
endpackage

// File: rtl/hwpf_stack.sv
// hwpf_stack: LIFO of prefetch candidate addresses; overflow silently drops the oldest entry
//   clk_i   : clock, all updates on the rising edge
//   rst_ni  : synchronous active-low reset, empties the stack
//   flush_i : discard all entries
//   lock_i  : freeze the stack, push/pop ignored
//   push_i  : push val_i this cycle
//   val_i   : value to push
//   pop_i   : remove the top entry this cycle
//   valid_o : stack non-empty
//   req_o   : top-of-stack entry, zero when empty
module hwpf_stack
    import drac_pkg::*;
#(
    parameter int  STACK_DEPTH = 2,
    parameter type cpu_addr_t  = drac_pkg::addr_t
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      flush_i,
    input  logic      lock_i,
    input  logic      push_i,
    input  cpu_addr_t val_i,
    input  logic      pop_i,
    output logic      valid_o,
    output cpu_addr_t req_o
);
    localparam int PW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
    localparam int CW = $clog2(STACK_DEPTH + 1);

    cpu_addr_t     storage [STACK_DEPTH];
    logic [PW-1:0] top;
    logic [CW-1:0] count;
    logic [PW-1:0] top_inc;
    logic [PW-1:0] top_dec;

    // Explicit wrap so non-power-of-two depths behave as a ring
    always_comb begin
        top_inc = (top == PW'(STACK_DEPTH - 1)) ? '0 : top + 1'b1;
        top_dec = (top == '0) ? PW'(STACK_DEPTH - 1) : top - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            top   <= '0;
            count <= '0;
        end else if (!lock_i) begin
            if (push_i && (!pop_i || count == '0)) begin
                // Full push lands on the oldest slot, overwriting it
                top              <= top_inc;
                storage[top_inc] <= val_i;
                count            <= (count == CW'(STACK_DEPTH)) ? count : count + 1'b1;
            end else if (push_i) begin
                storage[top] <= val_i;
            end else if (pop_i && count != '0) begin
                top   <= top_dec;
                count <= count - 1'b1;
            end
        end
    end

    assign valid_o = (count != '0);
    assign req_o   = valid_o ? storage[top] : '0;
endmodule

// File: tb/tb_hwpf_stack.sv
// tb_hwpf_stack: directed plan plus random traffic against a queue-based LIFO model
module tb_hwpf_stack;
    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst_n, flush, lock, push, pop;
    logic [39:0] val;
    logic        valid;
    logic [39:0] req;

    logic [39:0] q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    hwpf_stack dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .flush_i(flush),
        .lock_i (lock),
        .push_i (push),
        .val_i  (val),
        .pop_i  (pop),
        .valid_o(valid),
        .req_o  (req)
    );

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Newest entry at the back of the queue; overflow drops the front
    task automatic model();
        if (!rst_n || flush) q.delete();
        else if (lock) ;
        else if (push && pop && q.size() > 0) q[q.size()-1] = val;
        else if (push) begin
            if (q.size() == D) void'(q.pop_front());
            q.push_back(val);
        end else if (pop && q.size() > 0) void'(q.pop_back());
    endtask

    task automatic check_model(input string tag);
        logic [39:0] e;
        e = (q.size() > 0) ? q[q.size()-1] : 40'h0;
        check({tag, ".valid"}, {39'h0, valid}, {39'h0, q.size() > 0});
        check({tag, ".req"}, req, e);
    endtask

    task automatic cyc(input string tag, input logic r, input logic f, input logic l,
                       input logic pu, input logic po, input logic [39:0] v, input bit pre);
        rst_n = r; flush = f; lock = l; push = pu; pop = po; val = v;
        #1;
        if (pre) check_model({tag, ".pre"});
        @(posedge clk);
        model();
        #1;
        check_model(tag);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; lock = 1'b0; push = 1'b0; pop = 1'b0; val = '0;
        @(negedge clk);
        cyc("rst0", 0, 0, 0, 0, 0, 0, 0);
        cyc("rst1", 0, 0, 0, 0, 0, 0, 0);
        cyc("idle", 1, 0, 0, 0, 0, 0, 1);
        cyc("push1", 1, 0, 0, 1, 0, 40'hCAFE0001, 1);
        cyc("pop1", 1, 0, 0, 0, 1, 0, 1);
        cyc("push2", 1, 0, 0, 1, 0, 40'hCAFE0002, 1);
        cyc("pushpop3", 1, 0, 0, 1, 1, 40'hCAFE0003, 1);
        cyc("pop3", 1, 0, 0, 0, 1, 0, 1);
        cyc("ovf4", 1, 0, 0, 1, 0, 40'hCAFE0004, 1);
        cyc("ovf5", 1, 0, 0, 1, 0, 40'hCAFE0005, 1);
        cyc("ovf6", 1, 0, 0, 1, 0, 40'hCAFE0006, 1);
        cyc("ovf7pp", 1, 0, 0, 1, 1, 40'hCAFE0007, 1);
        cyc("ovfpop_a", 1, 0, 0, 0, 1, 0, 1);
        check("ovf_req5", req, 40'hCAFE0005);
        cyc("ovfpop_b", 1, 0, 0, 0, 1, 0, 1);
        check("ovf_empty", {39'h0, valid}, 40'h0);
        cyc("udf_pop", 1, 0, 0, 0, 1, 0, 1);
        cyc("udf_pp8", 1, 0, 0, 1, 1, 40'hCAFE0008, 1);
        cyc("udf_pop8", 1, 0, 0, 0, 1, 0, 1);
        cyc("udf_idle", 1, 0, 0, 0, 0, 0, 1);
        cyc("lk_pa", 1, 0, 0, 1, 0, 40'hCAFE0009, 1);
        cyc("lk_pb", 1, 0, 0, 1, 0, 40'hCAFE000A, 1);
        cyc("lock", 1, 0, 1, 1, 1, 40'hDEAD0000, 1);
        check("lock_req", req, 40'hCAFE000A);
        cyc("flush", 1, 1, 1, 1, 0, 40'hDEAD0001, 1);
        cyc("fl_pa", 1, 0, 0, 1, 0, 40'hCAFE000B, 1);
        cyc("rst_push", 0, 0, 0, 1, 0, 40'hDEAD0002, 1);
        for (int i = 0; i < 600; i++) begin
            logic [39:0] v;
            v = 40'({$urandom(), $urandom()});
            cyc("rand", $urandom_range(0, 49) != 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 9) < 4, v, 1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
